cam_gray_frontend: RTL and testbench

Camera pixel front-end that turns a raw RGB565 camera stream (vsync/href/pixel-enable) into grayscale or binarized pixels tagged with frame coordinates. It sits directly upstream of the left/right dark-pixel counter stage, which drives the bird-flap decision. It produces the `x_pos`/`y_pos`/`data` triple that stage samples on every clock, and parks the coordinates out of window when no pixel is valid.

---
 rtl/cam_gray_frontend.sv | 142 ++++++++++++++
 tb/tb_cam_gray_frontend.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_gray_frontend.sv
// Camera front-end: RGB565 stream to grayscale/binarized pixels with frame coordinates.
// Two-stage pipeline; coordinates are parked at 11'h7FF whenever no in-window pixel is presented.
module cam_gray_frontend #(
  parameter int         H_ACTIVE  = 200,
  parameter int         V_ACTIVE  = 164,
  parameter logic [7:0] THRESHOLD = 8'd100,
  parameter bit         BINARIZE  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        href_in,
  input  logic        de_in,
  input  logic [15:0] rgb_in,
  output logic [10:0] x_pos,
  output logic [10:0] y_pos,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        frame_start,
  output logic        frame_err
);

  logic        vsync_q, href_q;
  logic        vs_rise, href_fall;
  logic        synced_q, synced_d;
  logic [10:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [10:0] x_inc, y_inc, y_fin;
  logic        line_now;
  logic        line_err_q, line_err_d;
  logic        frame_err_q, frame_err_d;

  logic [7:0]  r8, g8, b8;
  logic [15:0] pr_d, pg_d, pb_d;
  logic [15:0] pr_q, pg_q, pb_q;
  logic        win_d, win_q, fs1_q;
  logic [10:0] x1_q, y1_q;
  logic [15:0] sum;
  logic [7:0]  luma, pix_d;

  logic [10:0] x_pos_q, y_pos_q;
  logic [7:0]  data_q;
  logic        valid_q, fs2_q;

  assign vs_rise   = vsync_in & ~vsync_q;
  assign href_fall = ~href_in & href_q;

  always_comb begin
    synced_d    = synced_q;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    line_err_d  = line_err_q;
    frame_err_d = frame_err_q;
    line_now    = 1'b0;
    // A pixel coinciding with an edge is counted first, then the edge applies.
    x_inc = (de_in && x_cnt_q != 11'h7FF) ? x_cnt_q + 11'd1 : x_cnt_q;
    y_inc = (y_cnt_q != 11'h7FF) ? y_cnt_q + 11'd1 : y_cnt_q;
    y_fin = href_fall ? y_inc : y_cnt_q;
    if (!synced_q) begin
      if (vs_rise) synced_d = 1'b1;
    end else begin
      line_now = href_fall && (y_cnt_q < 11'(V_ACTIVE)) && (x_inc != 11'(H_ACTIVE));
      if (vs_rise) begin
        x_cnt_d     = '0;
        y_cnt_d     = '0;
        frame_err_d = line_err_q | line_now | (y_fin != 11'(V_ACTIVE));
        line_err_d  = 1'b0;
      end else if (href_fall) begin
        x_cnt_d    = '0;
        y_cnt_d    = y_inc;
        line_err_d = line_err_q | line_now;
      end else begin
        x_cnt_d = x_inc;
      end
    end
  end

  always_comb begin
    r8    = {rgb_in[15:11], rgb_in[15:13]};
    g8    = {rgb_in[10:5],  rgb_in[10:9]};
    b8    = {rgb_in[4:0],   rgb_in[4:2]};
    pr_d  = 16'd77  * 16'(r8);
    pg_d  = 16'd150 * 16'(g8);
    pb_d  = 16'd29  * 16'(b8);
    win_d = synced_q && de_in && (x_cnt_q < 11'(H_ACTIVE)) && (y_cnt_q < 11'(V_ACTIVE));
    sum   = pr_q + pg_q + pb_q;
    luma  = 8'(sum >> 8);
    if (BINARIZE) pix_d = (luma >= THRESHOLD) ? 8'hFF : 8'h00;
    else          pix_d = luma;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      synced_q    <= 1'b0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      pr_q        <= '0;
      pg_q        <= '0;
      pb_q        <= '0;
      x1_q        <= 11'h7FF;
      y1_q        <= 11'h7FF;
      win_q       <= 1'b0;
      fs1_q       <= 1'b0;
      x_pos_q     <= 11'h7FF;
      y_pos_q     <= 11'h7FF;
      data_q      <= 8'hFF;
      valid_q     <= 1'b0;
      fs2_q       <= 1'b0;
    end else begin
      vsync_q     <= vsync_in;
      href_q      <= href_in;
      synced_q    <= synced_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
      pr_q        <= pr_d;
      pg_q        <= pg_d;
      pb_q        <= pb_d;
      x1_q        <= x_cnt_q;
      y1_q        <= y_cnt_q;
      win_q       <= win_d;
      fs1_q       <= vs_rise;
      x_pos_q     <= win_q ? x1_q : 11'h7FF;
      y_pos_q     <= win_q ? y1_q : 11'h7FF;
      data_q      <= win_q ? pix_d : 8'hFF;
      valid_q     <= win_q;
      fs2_q       <= fs1_q;
    end
  end

  assign x_pos       = x_pos_q;
  assign y_pos       = y_pos_q;
  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign frame_start = fs2_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_cam_gray_frontend.sv
// Scoreboard bench for cam_gray_frontend: binarizing and raw-luma instances share one stimulus stream.
module tb_cam_gray_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync_in, href_in, de_in;
  logic [15:0] rgb_in;
  logic [10:0] x_pos, y_pos, rx_pos, ry_pos;
  logic [7:0]  data_out, rdata_out;
  logic        valid_out, frame_start, frame_err;
  logic        rvalid_out, rframe_start, rframe_err;

  always #5 clk = ~clk;

  cam_gray_frontend dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .href_in(href_in), .de_in(de_in),
    .rgb_in(rgb_in), .x_pos(x_pos), .y_pos(y_pos), .data_out(data_out),
    .valid_out(valid_out), .frame_start(frame_start), .frame_err(frame_err));

  cam_gray_frontend #(.BINARIZE(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .href_in(href_in), .de_in(de_in),
    .rgb_in(rgb_in), .x_pos(rx_pos), .y_pos(ry_pos), .data_out(rdata_out),
    .valid_out(rvalid_out), .frame_start(rframe_start), .frame_err(rframe_err));

  typedef struct {int x; int y; int luma; int cyc;} pix_t;
  pix_t exp_q[$];
  int   fs_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, n_valid = 0;
  // Reference frame state, derived from what the bench drives
  bit   m_synced = 0, m_bad = 0, m_err = 0;
  int   m_line = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int luma_of(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(p[15:11]); g6 = int'(p[10:5]); b5 = int'(p[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  always @(negedge clk) begin
    pix_t e;
    if (!rst) begin
      chk("raw_valid_match", int'(rvalid_out), int'(valid_out));
      if (valid_out) begin
        n_valid++;
        if (exp_q.size() == 0) chk("unexpected_pixel", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pix_x", int'(x_pos), e.x);
          chk("pix_y", int'(y_pos), e.y);
          chk("pix_bin", int'(data_out), (e.luma >= 100) ? 255 : 0);
          chk("pix_raw", int'(rdata_out), e.luma);
          chk("pix_latency", cyc, e.cyc);
        end
      end else begin
        chk("park", int'({x_pos, y_pos, data_out}), int'({11'h7FF, 11'h7FF, 8'hFF}));
      end
      if (frame_start) begin
        if (fs_q.size() == 0) chk("unexpected_frame_start", 1, 0);
        else chk("frame_start_cycle", cyc, fs_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_pixel(input logic [15:0] p, input int x);
    tick();
    de_in  = 1'b1;
    rgb_in = p;
    if (m_synced && x < 200 && m_line < 164)
      exp_q.push_back('{x, m_line, luma_of(p), cyc + 2});
  endtask

  // mode 0: random, 1: constant val, 2: red/green/blue then random
  task automatic drive_line(input int n, input int mode, input logic [15:0] val);
    logic [15:0] p;
    tick();
    href_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(7) == 0) begin
        tick();
        de_in = 1'b0;
      end
      p = 16'($urandom);
      if (mode == 1) p = val;
      if (mode == 2 && i == 0) p = 16'hF800;
      if (mode == 2 && i == 1) p = 16'h07E0;
      if (mode == 2 && i == 2) p = 16'h001F;
      put_pixel(p, i);
    end
    tick();
    de_in   = 1'b0;
    href_in = 1'b0;
    tick();
    if (m_synced) begin
      if (m_line < 164 && n != 200) m_bad = 1;
      m_line++;
    end
  endtask

  task automatic vsync_pulse();
    tick();
    vsync_in = 1'b1;
    fs_q.push_back(cyc + 2);
    if (m_synced) m_err = m_bad || (m_line != 164);
    m_synced = 1;
    m_line   = 0;
    m_bad    = 0;
    tick();
    tick();
    vsync_in = 1'b0;
    tick();
    @(negedge clk);
    chk("frame_err", int'(frame_err), int'(m_err));
    chk("raw_frame_err", int'(rframe_err), int'(m_err));
  endtask

  int nv_hold;

  initial begin
    rst = 1'b1; vsync_in = 1'b0; href_in = 1'b0; de_in = 1'b0; rgb_in = '0;
    repeat (3) tick();
    chk("rst_x", int'(x_pos), 2047);
    chk("rst_y", int'(y_pos), 2047);
    chk("rst_data", int'(data_out), 255);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_err", int'(frame_err), 0);
    rst = 1'b0;

    drive_line(20, 0, 16'h0);
    repeat (3) tick();
    chk("presync_valid_count", n_valid, 0);

    vsync_pulse();
    drive_line(200, 1, 16'hFFFF);
    drive_line(200, 1, 16'h0000);
    drive_line(200, 2, 16'h0000);
    drive_line(210, 0, 16'h0000);
    vsync_pulse();

    for (int l = 0; l < 164; l++) drive_line(200, 0, 16'h0);
    vsync_pulse();

    tick();
    href_in = 1'b1;
    for (int i = 0; i < 57; i++) put_pixel(16'($urandom), i);
    tick();
    rgb_in = 16'($urandom);
    chk("inflight_valid", int'(valid_out), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", int'(valid_out), 0);
    chk("midrst_x", int'(x_pos), 2047);
    chk("midrst_y", int'(y_pos), 2047);
    chk("midrst_data", int'(data_out), 255);
    chk("midrst_err", int'(frame_err), 0);
    exp_q.delete();
    fs_q.delete();
    m_synced = 0; m_line = 0; m_bad = 0; m_err = 0;
    de_in = 1'b0;
    nv_hold = n_valid;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 58; i < 120; i++) put_pixel(16'($urandom), i);
    tick();
    de_in   = 1'b0;
    href_in = 1'b0;
    repeat (4) tick();
    chk("post_rst_no_valid", n_valid, nv_hold);

    vsync_pulse();
    drive_line(200, 0, 16'h0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("drain_pixels", exp_q.size(), 0);
    chk("drain_frame_start", fs_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
